// File: rtl/mode_control_router.sv
// Routes a shared switch bank into one of NUM_CH per-mode control registers.
// Enter-type channels commit staged data on an enter edge; LIVE channels track continuously.
//
//   state     | meaning
//   ----------+------------------------------------------------------------
//   ST_SELECT | channel just (re)selected: reload staging, no writes
//   ST_EDIT   | flags live; LIVE channels track staged data; wait for enter edge
//   ST_COMMIT | write staged data to the active channel and strobe its pulse
module mode_control_router #(
    parameter int                NUM_CH    = 3,
    parameter int                CH_W      = 2,
    parameter int                DATA_W    = 8,
    parameter int                FLAG_W    = 2,
    parameter logic [NUM_CH-1:0] LIVE_MASK = 3'b101
) (
    input  logic                                i_clock,
    input  logic                                i_reset_n,
    input  logic [NUM_CH-1:0]                   i_sel_req,
    input  logic [DATA_W-1:0]                   i_data_in,
    input  logic [FLAG_W-1:0]                   i_flags_in,
    input  logic                                i_enter,
    output logic [NUM_CH*(FLAG_W+DATA_W)-1:0]   o_ch_ctrl,
    output logic [NUM_CH-1:0]                   o_commit_pulse,
    output logic [CH_W-1:0]                     o_active_ch,
    output logic                                o_pending,
    output logic [CH_W+FLAG_W+DATA_W-1:0]       o_status
);

    localparam int CW = FLAG_W + DATA_W;

    typedef enum logic [1:0] {
        ST_SELECT = 2'd0,
        ST_EDIT   = 2'd1,
        ST_COMMIT = 2'd2
    } state_t;

    state_t                      r_state;
    state_t                      w_state_nxt;
    logic [CH_W-1:0]             r_active_ch;
    logic [DATA_W-1:0]           r_staged;
    logic                        r_enter_q;
    logic [DATA_W-1:0]           r_data  [NUM_CH];
    logic [FLAG_W-1:0]           r_flags [NUM_CH];
    logic [NUM_CH-1:0]           r_commit_pulse;
    logic [CH_W+FLAG_W+DATA_W-1:0] r_status;

    logic                        w_enter_edge;
    logic                        w_sel_any;
    logic [CH_W-1:0]             w_sel_idx;
    logic [DATA_W-1:0]           w_act_data;
    logic [FLAG_W-1:0]           w_act_flags;
    logic                        w_act_live;
    logic                        w_data_we;
    logic                        w_flags_we;
    logic                        w_force_pulse;
    logic                        w_pulse;

    assign w_enter_edge = i_enter & ~r_enter_q;
    assign w_sel_any    = |i_sel_req;

    // Scan high to low so the lowest set request bit wins.
    always_comb begin
        w_sel_idx = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (i_sel_req[i]) begin
                w_sel_idx = CH_W'(i);
            end
        end
    end

    always_comb begin
        w_act_data  = '0;
        w_act_flags = '0;
        w_act_live  = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (r_active_ch == CH_W'(i)) begin
                w_act_data  = r_data[i];
                w_act_flags = r_flags[i];
                w_act_live  = LIVE_MASK[i];
            end
        end
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state <= ST_SELECT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_data_we     = 1'b0;
        w_flags_we    = 1'b0;
        w_force_pulse = 1'b0;
        case (r_state)
            ST_SELECT: begin
                w_state_nxt = ST_EDIT;
            end
            ST_EDIT: begin
                w_flags_we = 1'b1;
                if (w_act_live) begin
                    w_data_we = 1'b1;
                end else if (w_enter_edge) begin
                    w_state_nxt = ST_COMMIT;
                end
            end
            ST_COMMIT: begin
                w_flags_we    = 1'b1;
                w_data_we     = 1'b1;
                w_force_pulse = 1'b1;
                w_state_nxt   = ST_EDIT;
            end
            default: begin
                w_state_nxt = ST_SELECT;
            end
        endcase
        // A selection request overrides the enter edge but lets a COMMIT finish.
        if (w_sel_any) begin
            w_state_nxt = ST_SELECT;
        end
    end

    assign w_pulse = w_data_we & (w_force_pulse | (r_staged != w_act_data));

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_active_ch    <= '0;
            r_staged       <= '0;
            r_enter_q      <= 1'b0;
            r_commit_pulse <= '0;
            r_status       <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                r_data[i]  <= '0;
                r_flags[i] <= '0;
            end
        end else begin
            r_enter_q <= i_enter;
            r_staged  <= i_data_in;
            r_status  <= {r_active_ch, w_act_flags, w_act_data};
            if (w_sel_any) begin
                r_active_ch <= w_sel_idx;
            end
            for (int i = 0; i < NUM_CH; i++) begin
                r_commit_pulse[i] <= (r_active_ch == CH_W'(i)) && w_pulse;
                if (r_active_ch == CH_W'(i)) begin
                    if (w_data_we) begin
                        r_data[i] <= r_staged;
                    end
                    if (w_flags_we) begin
                        r_flags[i] <= i_flags_in;
                    end
                end
            end
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ctrl
        assign o_ch_ctrl[g*CW +: CW] = {r_flags[g], r_data[g]};
    end

    assign o_pending      = (r_state != ST_SELECT) && !w_act_live && (r_staged != w_act_data);
    assign o_commit_pulse = r_commit_pulse;
    assign o_active_ch    = r_active_ch;
    assign o_status       = r_status;

endmodule
